// File: rtl/uxn_screen_cmd_sequencer_pkg.sv
// ============================================================================
// Module  : uxn_screen_cmd_sequencer_pkg
// Brief   : Shared FSM encodings, command field layout and step helper for the
//           Varvara screen command sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uxn_screen_cmd_sequencer_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_W0   = 3'd2;
    localparam logic [2:0] ST_W1   = 3'd3;
    localparam logic [2:0] ST_STEP = 3'd4;
    localparam logic [2:0] ST_WB   = 3'd5;

    localparam int unsigned COORD_W = 9;

    // Bit 7 is "fill" for pixel commands and "2bpp" for sprite commands.
    typedef struct packed {
        logic       mode;
        logic       layer;
        logic       fy;
        logic       fx;
        logic [3:0] color;
    } cmd_t;

    function automatic logic [15:0] step_delta(input logic        en,
                                               input logic        neg,
                                               input logic [15:0] step);
        if (!en) begin
            return 16'd0;
        end
        return neg ? (16'd0 - step) : step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uxn_draw_word_pack.sv
// ============================================================================
// Module  : uxn_draw_word_pack
// Brief   : Combinational packer from a screen command to the two 24-bit
//           draw-queue words, plus the all-zero word0 flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uxn_draw_word_pack
    import uxn_screen_cmd_sequencer_pkg::*;
(
    input  logic                 sprite,
    input  logic [7:0]           cmd_byte,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [15:0]          addr,
    output logic [23:0]          word0,
    output logic [23:0]          word1,
    output logic                 word0_zero
);

    cmd_t       w_cmd;
    logic [2:0] w_ftl;

    assign w_cmd = cmd_t'(cmd_byte);

    // Sprites always set t so their word0 can never look like an empty slot.
    always_comb begin
        if (sprite) begin
            w_ftl = {1'b0, 1'b1, w_cmd.mode};
        end else begin
            w_ftl = {w_cmd.mode, w_cmd.fy, w_cmd.fx};
        end
    end

    assign word0      = {w_cmd.layer, w_cmd.color[1:0], w_ftl, x, y};
    assign word1      = {4'b0000, w_cmd.fy, w_cmd.fx, w_cmd.color[3:2], addr};
    assign word0_zero = (word0 == 24'd0);

endmodule

`default_nettype wire

// File: rtl/uxn_screen_cmd_sequencer.sv
// ============================================================================
// Module  : uxn_screen_cmd_sequencer
// Brief   : Turns Varvara screen pixel/sprite commands into paced draw-queue
//           records and returns auto-advanced x/y/addr for write-back.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uxn_screen_cmd_sequencer
    import uxn_screen_cmd_sequencer_pkg::*;
#(
    parameter logic [15:0] SPR_STEP   = 16'd8,
    parameter logic [15:0] ADDR_STEP1 = 16'd8,
    parameter logic [15:0] ADDR_STEP2 = 16'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_sprite,
    input  logic [7:0]  cmd_byte,
    input  logic [7:0]  auto_byte,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] addr_in,
    input  logic        queue_ready,
    output logic [23:0] queue_data,
    output logic        queue_we,
    output logic        wb_valid,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [15:0] addr_out,
    output logic        busy
);

    logic [2:0]  state_q,     state_d;
    logic        sprite_q,    sprite_d;
    logic [7:0]  cmd_q,       cmd_d;
    logic [3:0]  len_q,       len_d;
    logic        auto_addr_q, auto_addr_d;
    logic        auto_y_q,    auto_y_d;
    logic        auto_x_q,    auto_x_d;
    logic [15:0] x_base_q,    x_base_d;
    logic [15:0] y_base_q,    y_base_d;
    logic [15:0] addr_base_q, addr_base_d;
    logic [15:0] cur_x_q,     cur_x_d;
    logic [15:0] cur_y_q,     cur_y_d;
    logic [15:0] cur_addr_q,  cur_addr_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [15:0] x_out_q,     x_out_d;
    logic [15:0] y_out_q,     y_out_d;
    logic [15:0] addr_out_q,  addr_out_d;

    cmd_t        w_cmd;
    logic [15:0] w_sx;
    logic [15:0] w_sy;
    logic [15:0] w_addr_inc;
    logic [15:0] w_wb_x;
    logic [15:0] w_wb_y;
    logic [15:0] w_wb_addr;
    logic [23:0] w_word0;
    logic [23:0] w_word1;
    logic        w_zero;
    logic        w_unused_auto_bit;

    assign w_unused_auto_bit = auto_byte[3];

    assign w_cmd      = cmd_t'(cmd_q);
    // Burst stepping pairs auto_y with fx and auto_x with fy; write-back does not.
    assign w_sx       = step_delta(auto_y_q, w_cmd.fx, SPR_STEP);
    assign w_sy       = step_delta(auto_x_q, w_cmd.fy, SPR_STEP);
    assign w_addr_inc = auto_addr_q ? (w_cmd.mode ? ADDR_STEP2 : ADDR_STEP1) : 16'd0;

    always_comb begin
        if (sprite_q) begin
            w_wb_x    = x_base_q + step_delta(auto_x_q, w_cmd.fx, SPR_STEP);
            w_wb_y    = y_base_q + step_delta(auto_y_q, w_cmd.fy, SPR_STEP);
            w_wb_addr = cur_addr_q + w_addr_inc;
        end else begin
            w_wb_x    = x_base_q + {15'd0, auto_x_q};
            w_wb_y    = y_base_q + {15'd0, auto_y_q};
            w_wb_addr = addr_base_q;
        end
    end

    uxn_draw_word_pack u_pack (
        .sprite     (sprite_q),
        .cmd_byte   (cmd_q),
        .x          (cur_x_q[COORD_W-1:0]),
        .y          (cur_y_q[COORD_W-1:0]),
        .addr       (cur_addr_q),
        .word0      (w_word0),
        .word1      (w_word1),
        .word0_zero (w_zero)
    );

    always_comb begin
        state_d     = state_q;
        sprite_d    = sprite_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        auto_addr_d = auto_addr_q;
        auto_y_d    = auto_y_q;
        auto_x_d    = auto_x_q;
        x_base_d    = x_base_q;
        y_base_d    = y_base_q;
        addr_base_d = addr_base_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_addr_d  = cur_addr_q;
        cnt_d       = cnt_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        addr_out_d  = addr_out_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    sprite_d    = cmd_sprite;
                    cmd_d       = cmd_byte;
                    len_d       = auto_byte[7:4];
                    auto_addr_d = auto_byte[2];
                    auto_y_d    = auto_byte[1];
                    auto_x_d    = auto_byte[0];
                    x_base_d    = x_in;
                    y_base_d    = y_in;
                    addr_base_d = addr_in;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cur_x_d    = x_base_q;
                cur_y_d    = y_base_q;
                cur_addr_d = addr_base_q;
                cnt_d      = sprite_q ? len_q : 4'd0;
                state_d    = ST_W0;
            end
            ST_W0: begin
                // An all-zero word would read as an empty slot, so it is skipped.
                if (w_zero || (queue_ready && !sprite_q)) begin
                    x_out_d    = w_wb_x;
                    y_out_d    = w_wb_y;
                    addr_out_d = w_wb_addr;
                    state_d    = ST_WB;
                end else if (queue_ready) begin
                    state_d = ST_W1;
                end
            end
            ST_W1: begin
                state_d = ST_STEP;
            end
            ST_STEP: begin
                cur_addr_d = cur_addr_q + w_addr_inc;
                if (cnt_q == 4'd0) begin
                    x_out_d    = w_wb_x;
                    y_out_d    = w_wb_y;
                    addr_out_d = w_wb_addr;
                    state_d    = ST_WB;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    cur_x_d = cur_x_q + w_sx;
                    cur_y_d = cur_y_q + w_sy;
                    state_d = ST_W0;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sprite_q    <= 1'b0;
            cmd_q       <= 8'd0;
            len_q       <= 4'd0;
            auto_addr_q <= 1'b0;
            auto_y_q    <= 1'b0;
            auto_x_q    <= 1'b0;
            x_base_q    <= 16'd0;
            y_base_q    <= 16'd0;
            addr_base_q <= 16'd0;
            cur_x_q     <= 16'd0;
            cur_y_q     <= 16'd0;
            cur_addr_q  <= 16'd0;
            cnt_q       <= 4'd0;
            x_out_q     <= 16'd0;
            y_out_q     <= 16'd0;
            addr_out_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            sprite_q    <= sprite_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            auto_addr_q <= auto_addr_d;
            auto_y_q    <= auto_y_d;
            auto_x_q    <= auto_x_d;
            x_base_q    <= x_base_d;
            y_base_q    <= y_base_d;
            addr_base_q <= addr_base_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_addr_q  <= cur_addr_d;
            cnt_q       <= cnt_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            addr_out_q  <= addr_out_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign wb_valid   = (state_q == ST_WB);
    assign queue_we   = ((state_q == ST_W0) && queue_ready && !w_zero) || (state_q == ST_W1);
    assign queue_data = (state_q == ST_W0) ? w_word0 :
                        (state_q == ST_W1) ? w_word1 : 24'd0;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign addr_out   = addr_out_q;

endmodule

`default_nettype wire
